thunderbird_seq: RTL and testbench

- Sequential tail-light controller for the ThunderBird signal design.
- Converts the left, right and hazard switch inputs into the timed 6-bit light pattern.
- That pattern feeds the 16-segment display decoder directly downstream.
- Contains a tick prescaler and a Moore FSM; the output pattern is registered.

---
 rtl/thunderbird_seq.sv | 105 ++++++++++
 tb/tb_thunderbird_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thunderbird_seq.sv
// ThunderBird tail-light sequencer: tick prescaler plus Moore FSM whose state register is lights.
// Define TBIRD_INSYNC_EN to pass left/right/hazard through 2-flop synchronizers first.
module thunderbird_seq #(
    parameter int unsigned TICK_DIV = 12500000,
    parameter int unsigned CNT_W    = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
    output logic [5:0] lights,
    output logic       tick
);

    typedef enum logic [5:0] {
        StIdle = 6'b000000,
        StL1   = 6'b001000,
        StL2   = 6'b011000,
        StL3   = 6'b111000,
        StR1   = 6'b000100,
        StR2   = 6'b000110,
        StR3   = 6'b000111,
        StHaz  = 6'b111111
    } state_t;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] counter;
    state_t           state;
    logic             left_s;
    logic             right_s;
    logic             hazard_s;
    logic             haz_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (counter == CntMax);
            counter <= (counter == CntMax) ? '0 : counter + CNT_W'(1);
        end
    end

`ifdef TBIRD_INSYNC_EN
    logic [1:0] left_sync;
    logic [1:0] right_sync;
    logic [1:0] hazard_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_sync   <= 2'b00;
            right_sync  <= 2'b00;
            hazard_sync <= 2'b00;
        end else begin
            left_sync   <= {left_sync[0], left};
            right_sync  <= {right_sync[0], right};
            hazard_sync <= {hazard_sync[0], hazard};
        end
    end

    assign left_s   = left_sync[1];
    assign right_s  = right_sync[1];
    assign hazard_s = hazard_sync[1];
`else
    assign left_s   = left;
    assign right_s  = right;
    assign hazard_s = hazard;
`endif

    // Both turn switches together behave exactly like the hazard switch.
    assign haz_req = hazard_s | (left_s & right_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
        end else if (tick) begin
            case (state)
                StIdle: begin
                    if (haz_req) begin
                        state <= StHaz;
                    end else if (left_s) begin
                        state <= StL1;
                    end else if (right_s) begin
                        state <= StR1;
                    end else begin
                        state <= StIdle;
                    end
                end
                StL1:    state <= haz_req ? StHaz : StL2;
                StL2:    state <= haz_req ? StHaz : StL3;
                StL3:    state <= haz_req ? StHaz : StIdle;
                StR1:    state <= haz_req ? StHaz : StR2;
                StR2:    state <= haz_req ? StHaz : StR3;
                StR3:    state <= haz_req ? StHaz : StIdle;
                StHaz:   state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    assign lights = state;

endmodule

// File: tb/tb_thunderbird_seq.sv
// Bench for thunderbird_seq with TICK_DIV=4: table-driven tick sequences, reset and latency
// corners, then random switch activity checked every cycle against a mode/step reference model.
module tb_thunderbird_seq;

    localparam int unsigned TD = 4;

    localparam logic [5:0] IDLE = 6'b000000;
    localparam logic [5:0] L1   = 6'b001000;
    localparam logic [5:0] L2   = 6'b011000;
    localparam logic [5:0] L3   = 6'b111000;
    localparam logic [5:0] R1   = 6'b000100;
    localparam logic [5:0] R2   = 6'b000110;
    localparam logic [5:0] R3   = 6'b000111;
    localparam logic [5:0] HAZ  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       hazard = 1'b0;
    logic [5:0] lights;
    logic       tick;

    int n_checks;
    int n_fail;

    thunderbird_seq #(.TICK_DIV(TD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .left   (left),
        .right  (right),
        .hazard (hazard),
        .lights (lights),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=none 1=left 2=right 3=hazard, step 1..3 within a turn sequence.
    int         m_edges;
    int         m_mode;
    int         m_step;
    logic       m_tick;
    logic [2:0] d1;
    logic [2:0] d2;
    logic [2:0] m_in;
    logic [5:0] m_lights;

    function automatic logic [5:0] pattern(int mode, int step);
        logic [2:0] lamps;
        if (mode == 3) return 6'b111111;
        if (mode == 1) begin
            lamps = 3'((1 << step) - 1);
            return {lamps, 3'b000};
        end
        if (mode == 2) begin
            lamps = 3'(7 << (3 - step));
            return {3'b000, lamps};
        end
        return 6'b000000;
    endfunction

    function automatic int next_code(int mode, int step, logic [2:0] in);
        logic l, r, h;
        {l, r, h} = in;
        if (mode == 3) return 0;
        if (h || (l && r)) return 12;
        if (mode == 0) return l ? 5 : (r ? 9 : 0);
        if (step == 3) return 0;
        return mode * 4 + step + 1;
    endfunction

`ifdef TBIRD_INSYNC_EN
    assign m_in = d2;
`else
    assign m_in = {left, right, hazard};
`endif
    assign m_lights = pattern(m_mode, m_step);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edges <= 0;
            m_mode  <= 0;
            m_step  <= 0;
            m_tick  <= 1'b0;
            d1      <= 3'b000;
            d2      <= 3'b000;
        end else begin
            d1 <= {left, right, hazard};
            d2 <= d1;
            if (m_tick) begin
                m_mode <= next_code(m_mode, m_step, m_in) / 4;
                m_step <= next_code(m_mode, m_step, m_in) % 4;
            end
            m_edges <= m_edges + 1;
            m_tick  <= ((m_edges + 1) % int'(TD)) == 0;
        end
    end

    typedef struct {
        logic       l;
        logic       r;
        logic       h;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string name, logic [5:0] act, logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("tick_vs_model", {5'b0, tick}, {5'b0, m_tick});
        chk("lights_vs_model", lights, m_lights);
    endtask

    // Advance to the negedge just after a state-update edge.
    task automatic align();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * int'(TD); i++) begin
            if ((m_edges % int'(TD)) == 1 && m_edges > 1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL align: no update edge within budget, edges=%0d", m_edges);
        end
    endtask

    task automatic tick_step(logic l, logic r, logic h);
        left   = l;
        right  = r;
        hazard = h;
        repeat (TD) cyc();
    endtask

    initial begin
        int cnt;
        n_checks = 0;
        n_fail   = 0;

        #2 rst_n = 1'b0;
        #1;
        chk("reset_lights", lights, IDLE);
        chk("reset_tick", {5'b0, tick}, 6'b0);
        repeat (2) @(negedge clk);
        chk("reset_hold_lights", lights, IDLE);
        chk("reset_hold_tick", {5'b0, tick}, 6'b0);
        rst_n = 1'b1;

        // First tick after release, then the tick period.
        cnt = 0;
        for (int i = 1; i <= 3 * int'(TD); i++) begin
            cyc();
            if (tick) begin
                cnt = i;
                break;
            end
        end
        chk("first_tick_cycle", 6'(cnt), 6'(TD));
        cnt = 0;
        for (int i = 1; i <= 3 * int'(TD); i++) begin
            cyc();
            if (tick) begin
                cnt = i;
                break;
            end
        end
        chk("tick_period", 6'(cnt), 6'(TD));

        // Left held; left released; right one tick; hazard override; L+R; side switch.
        tbl.push_back('{1'b1, 1'b0, 1'b0, L1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, L2});
        tbl.push_back('{1'b1, 1'b0, 1'b0, L3});
        tbl.push_back('{1'b1, 1'b0, 1'b0, IDLE});
        tbl.push_back('{1'b1, 1'b0, 1'b0, L1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, L2});
        tbl.push_back('{1'b0, 1'b0, 1'b0, L3});
        tbl.push_back('{1'b0, 1'b0, 1'b0, IDLE});
        tbl.push_back('{1'b0, 1'b1, 1'b0, R1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, R2});
        tbl.push_back('{1'b0, 1'b0, 1'b0, R3});
        tbl.push_back('{1'b0, 1'b0, 1'b0, IDLE});
        tbl.push_back('{1'b0, 1'b0, 1'b0, IDLE});
        tbl.push_back('{1'b1, 1'b0, 1'b0, L1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, L2});
        tbl.push_back('{1'b1, 1'b0, 1'b1, HAZ});
        tbl.push_back('{1'b1, 1'b0, 1'b1, IDLE});
        tbl.push_back('{1'b1, 1'b0, 1'b1, HAZ});
        tbl.push_back('{1'b0, 1'b0, 1'b0, IDLE});
        tbl.push_back('{1'b1, 1'b1, 1'b0, HAZ});
        tbl.push_back('{1'b0, 1'b0, 1'b0, IDLE});
        tbl.push_back('{1'b1, 1'b0, 1'b0, L1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, L2});
        tbl.push_back('{1'b0, 1'b1, 1'b0, L3});
        tbl.push_back('{1'b0, 1'b1, 1'b0, IDLE});
        tbl.push_back('{1'b0, 1'b1, 1'b0, R1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, R2});
        tbl.push_back('{1'b0, 1'b0, 1'b0, R3});
        tbl.push_back('{1'b0, 1'b0, 1'b0, IDLE});

        align();
        foreach (tbl[i]) begin
            tick_step(tbl[i].l, tbl[i].r, tbl[i].h);
            chk($sformatf("table[%0d]", i), lights, tbl[i].exp);
        end

`ifdef TBIRD_INSYNC_EN
        // Left rising two clocks before the tick pulse is seen.
        align();
        cyc();
        left = 1'b1;
        repeat (3) cyc();
        chk("sync_2clk_before", lights, L1);
        tick_step(1'b0, 1'b0, 1'b0);
        tick_step(1'b0, 1'b0, 1'b0);
        tick_step(1'b0, 1'b0, 1'b0);
        chk("sync_seq_done", lights, IDLE);
        // Left rising one clock before the tick pulse is missed.
        repeat (2) cyc();
        left = 1'b1;
        repeat (2) cyc();
        chk("sync_1clk_before", lights, IDLE);
        left = 1'b0;
        repeat (TD) cyc();
        chk("sync_late_pulse_gone", lights, IDLE);
`else
        // Left rising in the cycle just before the update edge is seen.
        align();
        repeat (TD - 1) cyc();
        left = 1'b1;
        cyc();
        chk("raw_late_rise", lights, L1);
        tick_step(1'b0, 1'b0, 1'b0);
        tick_step(1'b0, 1'b0, 1'b0);
        tick_step(1'b0, 1'b0, 1'b0);
        chk("raw_seq_done", lights, IDLE);
        // A pulse not covering the update edge is ignored.
        cyc();
        left = 1'b1;
        cyc();
        left = 1'b0;
        repeat (TD - 1) cyc();
        chk("raw_short_pulse", lights, IDLE);
`endif

        // Asynchronous reset in L2, mid-count.
        align();
        tick_step(1'b1, 1'b0, 1'b0);
        tick_step(1'b1, 1'b0, 1'b0);
        chk("pre_reset_l2", lights, L2);
        left = 1'b0;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_lights", lights, IDLE);
        chk("async_reset_tick", {5'b0, tick}, 6'b0);
        @(negedge clk);
        chk("async_reset_hold", lights, IDLE);
        rst_n = 1'b1;

        // Random switch activity.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                left   = 1'($urandom_range(0, 1));
                right  = 1'($urandom_range(0, 1));
                hazard = ($urandom_range(0, 7) == 0);
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
